// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: reserved instruction words, opcode field
// position and the fetch FSM state encoding.
package fetch_stage_pkg;

    localparam logic [15:0] NOP_INSTR  = 16'h0000;
    localparam logic [15:0] HALT_INSTR = 16'hFFFF;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 13;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return (instr == HALT_INSTR);
    endfunction

    function automatic logic [2:0] opcode_of(input logic [15:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: reset, load of a redirect target, hold, or increment
// wrapping modulo 2^ADDR_W. Priority: reset > load > hold > increment.
module pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_inc_s;

    // Natural overflow of the adder gives the wrap with no carry flag.
    always_comb begin
        pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end

    // PC state update.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC[ADDR_W-1:0];
        end else if (load) begin
            pc_r <= target;
        end else if (hold) begin
            pc_r <= pc_r;
        end else begin
            pc_r <= pc_inc_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, RUN/HALT control and the IF/ID buffer feeding
// decode. Memory read is combinational on the current PC.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [15:0]       instruction_buf,
    output logic [ADDR_W-1:0] pc_buf,
    output logic              valid_buf,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    fetch_state_t      state_r;
    logic [15:0]       instr_r;
    logic [ADDR_W-1:0] pc_buf_r;
    logic              valid_r;
    logic              halted_r;
    logic [15:0]       count_r;
    logic [ADDR_W-1:0] pc_s;
    logic              pc_hold_s;
    logic              halt_seen_s;

    // PC is frozen on stall, on the fetch of a HALT word, and while halted.
    always_comb begin
        halt_seen_s = is_halt(imem_data);
        if (state_r == ST_HALT) begin
            pc_hold_s = 1'b1;
        end else begin
            pc_hold_s = stall | halt_seen_s;
        end
    end

    pc_reg #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W)
    ) u_pc_reg (
        .clk    (clk),
        .reset  (reset),
        .hold   (pc_hold_s),
        .load   (branch_taken),
        .target (branch_target),
        .pc     (pc_s)
    );

    // Fetch FSM and IF/ID buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_RUN;
            instr_r  <= NOP_INSTR;
            pc_buf_r <= {ADDR_W{1'b0}};
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
            count_r  <= 16'h0000;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (branch_taken) begin
                        instr_r <= NOP_INSTR;
                        valid_r <= 1'b0;
                    end else if (stall) begin
                        instr_r <= instr_r;
                        valid_r <= valid_r;
                    end else begin
                        instr_r  <= imem_data;
                        pc_buf_r <= pc_s;
                        valid_r  <= 1'b1;
                        if (count_r != 16'hFFFF) begin
                            count_r <= count_r + 16'h0001;
                        end
                        if (halt_seen_s) begin
                            state_r  <= ST_HALT;
                            halted_r <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    instr_r <= NOP_INSTR;
                    valid_r <= 1'b0;
                    if (branch_taken) begin
                        state_r  <= ST_RUN;
                        halted_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_RUN;
                    halted_r <= 1'b0;
                    instr_r  <= NOP_INSTR;
                    valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr       = pc_s;
    assign instruction_buf = instr_r;
    assign pc_buf          = pc_buf_r;
    assign valid_buf       = valid_r;
    assign halted          = halted_r;
    assign fetch_count     = count_r;

endmodule
